// File: rtl/hex_display_scanner_pkg.sv
// Shared constants for the seven-segment display path.
// Segment codes are active-low, bit0 = a .. bit6 = g.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h27, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_code(
    input logic [3:0] nib
  );
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low
// seven-segment pattern.
module hex_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = seg_code(i_nib);

endmodule

// File: rtl/hex_display_scanner.sv
// Multi-digit hex display driver: scanned and static
// outputs, frame-synchronous update, LZ blank, blink.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic [7*NUM_DIGITS-1:0] hex_n,
  output logic                    frame_tick,
  output logic                    upd_pending
);

  localparam int VW = 4*NUM_DIGITS;
  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_MAX = PW'(SCAN_DIV-1);
  localparam logic [IW-1:0] I_MAX = IW'(NUM_DIGITS-1);
  localparam logic [FW-1:0] F_MAX =
    FW'(BLINK_FRAMES-1);

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_disp;
  logic [VW-1:0]         r_pend;
  logic                  r_pflag;
  logic [FW-1:0]         r_fcnt;
  logic                  r_phase;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic                  r_tick;

  logic                    w_step;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [7*NUM_DIGITS-1:0] w_hex;
  logic [3:0]              w_scan_nib;
  logic [6:0]              w_scan_code;
  logic [NUM_DIGITS-1:0]   w_dig;

  assign w_step = (r_pre == P_MAX);
  assign w_wrap = w_step && (r_idx == I_MAX);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [6:0] w_code;

    hex_seg_decoder u_dec (
      .i_nib   (r_disp[4*g +: 4]),
      .o_seg_n (w_code)
    );

    // Digit 0 always shows, even for an all-zero value.
    if (g == 0) begin : g_lsd
      assign w_lz[g] = 1'b0;
    end else begin : g_upper
      assign w_lz[g] = (r_disp[VW-1:4*g] == '0);
    end

    assign w_blank[g] =
      (blink_en[g] & r_phase) | (blank_lz & w_lz[g]);
    assign w_hex[7*g +: 7] =
      w_blank[g] ? SEG_BLANK : w_code;
  end

  assign w_scan_nib = r_disp[{r_idx, 2'b00} +: 4];

  hex_seg_decoder u_scan_dec (
    .i_nib   (w_scan_nib),
    .o_seg_n (w_scan_code)
  );

  assign w_dig =
    ~(NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_disp  <= '0;
      r_pend  <= '0;
      r_pflag <= 1'b0;
      r_fcnt  <= '0;
      r_phase <= 1'b0;
      r_seg   <= SEG_BLANK;
      r_dig   <= '1;
      r_hex   <= '1;
      r_tick  <= 1'b0;
    end else begin
      r_seg  <= w_blank[r_idx] ? SEG_BLANK
                               : w_scan_code;
      r_dig  <= w_dig;
      r_hex  <= w_hex;
      r_tick <= w_wrap;

      r_pre <= w_step ? '0 : r_pre + 1'b1;
      if (w_step) begin
        r_idx <= (r_idx == I_MAX) ? '0
                                  : r_idx + 1'b1;
      end

      // A load on the wrap edge bypasses pending.
      if (load && w_wrap) begin
        r_disp  <= value;
        r_pflag <= 1'b0;
      end else if (load) begin
        r_pend  <= value;
        r_pflag <= 1'b1;
      end else if (w_wrap && r_pflag) begin
        r_disp  <= r_pend;
        r_pflag <= 1'b0;
      end

      if (w_wrap) begin
        if (r_fcnt == F_MAX) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  assign seg_n       = r_seg;
  assign dig_n       = r_dig;
  assign hex_n       = r_hex;
  assign frame_tick  = r_tick;
  assign upd_pending = r_pflag;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against
// a cycle-level behavioural reference.
module tb_hex_display_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] blink_en = '0;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_n;
  logic [27:0]   hex_n;
  logic          frame_tick;
  logic          upd_pending;

  int n_chk = 0;
  int n_err = 0;

  hex_display_scanner #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .hex_n       (hex_n),
    .frame_tick  (frame_tick),
    .upd_pending (upd_pending)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h27, 7'h21, 7'h06, 7'h0E
  };

  // Reference state
  int          m_pre, m_idx, m_fcnt;
  logic        m_phase, m_pflag;
  logic [15:0] m_disp, m_pend;
  logic [6:0]  e_seg;
  logic [3:0]  e_dig;
  logic [27:0] e_hex;
  logic        e_tick;

  function automatic logic [6:0] digit_code(
    input int i
  );
    int  nib;
    bit  lz, bl;
    nib = int'((m_disp >> (4*i)) & 16'hF);
    lz  = (i > 0) && ((m_disp >> (4*i)) == 16'h0);
    bl  = (blink_en[i] && m_phase) || (blank_lz && lz);
    return bl ? 7'h7F : tbl[nib];
  endfunction

  always @(posedge clk) begin
    bit wrap;
    if (!rst_n) begin
      m_pre = 0; m_idx = 0; m_fcnt = 0;
      m_phase = 0; m_pflag = 0;
      m_disp = '0; m_pend = '0;
      e_seg = 7'h7F; e_dig = 4'hF;
      e_hex = '1; e_tick = 0;
    end else begin
      for (int i = 0; i < ND; i++) begin
        e_hex[7*i +: 7] = digit_code(i);
      end
      e_seg  = digit_code(m_idx);
      e_dig  = ~(4'b0001 << m_idx);
      wrap   = (m_pre == SD-1) && (m_idx == ND-1);
      e_tick = wrap;
      if (load && wrap) begin
        m_disp = value; m_pflag = 0;
      end else if (load) begin
        m_pend = value; m_pflag = 1;
      end else if (wrap && m_pflag) begin
        m_disp = m_pend; m_pflag = 0;
      end
      if (wrap) begin
        m_fcnt = m_fcnt + 1;
        if (m_fcnt == BF) begin
          m_fcnt = 0; m_phase = ~m_phase;
        end
      end
      m_pre = m_pre + 1;
      if (m_pre == SD) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % ND;
      end
    end
    #1;
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("dig_n", 32'(dig_n), 32'(e_dig));
    check("hex_n", 32'(hex_n), 32'(e_hex));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("upd_pending", 32'(upd_pending),
          32'(m_pflag));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    value = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge just before the edge where
  // the reference is about to reach the given state.
  task automatic wait_state(input int idx, input int pre);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_idx == idx && m_pre == pre) return;
    end
    check("wait_state_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    cyc(3);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dig", 32'(dig_n), 32'hF);
    check("rst_hex", 32'(hex_n), 32'hFFFFFFF);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("rel_dig", 32'(dig_n), 32'hE);
    check("rel_seg", 32'(seg_n), 32'h40);

    do_load(16'h1A3F);
    check("load_pend", 32'(upd_pending), 32'h1);
    cyc(40);
    check("hex_1A3F", 32'(hex_n),
          32'({7'h79, 7'h08, 7'h30, 7'h0E}));

    wait_state(2, 1);
    value = 16'h1234; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("mid_pend", 32'(upd_pending), 32'h1);
    cyc(40);
    check("hex_1234", 32'(hex_n),
          32'({7'h79, 7'h24, 7'h30, 7'h19}));

    blank_lz = 1'b1;
    do_load(16'h0050);
    cyc(40);
    check("lz_0050", 32'(hex_n),
          32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
    do_load(16'h0000);
    cyc(40);
    check("lz_0000", 32'(hex_n),
          32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    blank_lz = 1'b0;

    blink_en = 4'b0001;
    do_load(16'h8888);
    cyc(160);
    blink_en = '0;

    wait_state(ND-1, SD-1);
    value = 16'hBEEF; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("wrap_load_pend", 32'(upd_pending), 32'h0);
    cyc(20);

    do_load(16'hC0DE);
    wait_state(2, 0);
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_pend", 32'(upd_pending), 32'h0);
    rst_n = 1'b1;
    cyc(40);
    check("post_rst_hex", 32'(hex_n),
          32'({7'h40, 7'h40, 7'h40, 7'h40}));

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 9) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value[15:8] = '0;
      if ($urandom_range(0, 39) == 0)
        blank_lz = 1'($urandom);
      if ($urandom_range(0, 39) == 0)
        blink_en = 4'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    load = 1'b0; rst_n = 1'b1;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
